// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcodes and the decoded-bundle type
// used by both the ALU and its issue stage.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h11;
    localparam logic [7:0] ALU_SUB = 8'h12;
    localparam logic [7:0] ALU_MUL = 8'h13;
    localparam logic [7:0] ALU_DIV = 8'h14;
    localparam logic [7:0] ALU_MOD = 8'h15;
    localparam logic [7:0] ALU_AND = 8'h21;
    localparam logic [7:0] ALU_OR  = 8'h22;
    localparam logic [7:0] ALU_XOR = 8'h23;
    localparam logic [7:0] ALU_INV = 8'h24;
    localparam logic [7:0] ALU_SLT = 8'h31;
    localparam logic [7:0] ALU_SLL = 8'h33;
    localparam logic [7:0] ALU_SRL = 8'h34;
    localparam logic [7:0] ALU_SRA = 8'h35;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [7:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32 OP/OP-IMM/LUI/AUIPC decode into ALU op and operands.
// Unsupported encodings yield a NOP bundle flagged illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output dec_t        dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ok;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign shamt = {27'd0, instr_i[24:20]};

    always_comb begin
        op = ALU_NOP;
        a  = '0;
        b  = '0;
        ok = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                a  = rs1_i;
                b  = rs2_i;
                ok = 1'b1;
                case ({f7, f3})
                    {F7_BASE, 3'b000}:   op = ALU_ADD;
                    {F7_BASE, 3'b001}:   op = ALU_SLL;
                    {F7_BASE, 3'b010}:   op = ALU_SLT;
                    {F7_BASE, 3'b100}:   op = ALU_XOR;
                    {F7_BASE, 3'b101}:   op = ALU_SRL;
                    {F7_BASE, 3'b110}:   op = ALU_OR;
                    {F7_BASE, 3'b111}:   op = ALU_AND;
                    {F7_ALT, 3'b000}:    op = ALU_SUB;
                    {F7_ALT, 3'b101}:    op = ALU_SRA;
                    {F7_MULDIV, 3'b000}: op = ALU_MUL;
                    {F7_MULDIV, 3'b100}: op = ALU_DIV;
                    {F7_MULDIV, 3'b110}: op = ALU_MOD;
                    default:             ok = 1'b0;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                a  = rs1_i;
                b  = imm_i;
                ok = 1'b1;
                case (f3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        op = ALU_SLL;
                        b  = shamt;
                        ok = (f7 == F7_BASE);
                    end
                    3'b101: begin
                        op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        b  = shamt;
                        ok = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    default: ok = 1'b0;
                endcase
            end
            (opc == OPC_LUI): begin
                op = ALU_ADD;
                b  = imm_u;
                ok = 1'b1;
            end
            (opc == OPC_AUIPC): begin
                op = ALU_ADD;
                a  = pc_i;
                b  = imm_u;
                ok = 1'b1;
            end
            default: ok = 1'b0;
        endcase
    end

    // rd is passed through even for illegal encodings; only we is gated.
    always_comb begin
        dec_o         = '0;
        dec_o.rd      = instr_i[11:7];
        dec_o.illegal = !ok;
        if (ok) begin
            dec_o.op = op;
            dec_o.a  = a;
            dec_o.b  = b;
            dec_o.we = (instr_i[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one registered valid/ready slot holding the decoded
// op, operands and writeback info for the ALU.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_rs1_val,
    input  logic [DATA_WIDTH-1:0] i_rs2_val,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_alu_op,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [4:0]            o_rd,
    output logic                  o_we,
    output logic                  o_illegal
);

    dec_t dec;
    dec_t slot_q;
    dec_t slot_d;
    logic valid_q;
    logic valid_d;
    logic load;

    alu_op_decode u_dec (
        .instr_i (i_instr),
        .pc_i    (i_pc),
        .rs1_i   (i_rs1_val),
        .rs2_i   (i_rs2_val),
        .dec_o   (dec)
    );

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready;

    // Flush wins over both load and drain.
    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            slot_d  = dec;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_alu_op  = slot_q.op;
    assign o_a       = slot_q.a;
    assign o_b       = slot_q.b;
    assign o_rd      = slot_q.rd;
    assign o_we      = slot_q.we;
    assign o_illegal = slot_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Pipeline stage directly upstream of the ALU. Accepts one RV32 instruction per handshake, with the register-file operand values and the PC. Decodes OP, OP-IMM, LUI and AUIPC into an 8-bit ALU op code and selects the A/B operands. Presents the result from a single registered valid/ready output slot that feeds the ALU's op/a/b inputs and carries rd to writeback.

Parameters:
- DATA_WIDTH, 32, operand/PC width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous kill of the held output slot
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept this cycle
- i_instr  in  32  raw instruction word
- i_pc  in  32  instruction PC
- i_rs1_val  in  32  rs1 register value
- i_rs2_val  in  32  rs2 register value
- o_valid  out  1  output slot holds an instruction
- i_ready  in  1  downstream (ALU/EX) accepts
- o_alu_op  out  8  ALU op code for the ALU's op input
- o_a  out  32  operand A
- o_b  out  32  operand B
- o_rd  out  5  destination register
- o_we  out  1  writeback enable (rd!=0 and legal)
- o_illegal  out  1  unsupported or unknown encoding

Behaviour:
- Reset (async, i_rst_n low): all outputs registered to 0, including o_valid=0 and o_alu_op=NOP (8'h00). o_ready is combinational and equals 1 during and after reset.
- Handshake: o_ready = !o_valid || i_ready.
  - Load when i_valid && o_ready; o_valid=1 on the next edge. Latency is 1 cycle.
  - If o_valid && i_ready with no new load, o_valid clears.
  - While o_valid && !i_ready, all outputs hold stable.
- Flush has priority over load: i_flush=1 forces o_valid=0 next edge and drops any concurrent input; o_ready is still reported as computed. A reset asserted mid-transfer discards the slot.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP 0110011, a=rs1_val, b=rs2_val:
    - f7=0000000: f3 000 ADD 8'h11, 001 SLL 8'h33, 010 SLT 8'h31, 100 XOR 8'h23, 101 SRL 8'h34, 110 OR 8'h22, 111 AND 8'h21.
    - f7=0100000: f3 000 SUB 8'h12, 101 SRA 8'h35.
    - f7=0000001: f3 000 MUL 8'h13, 100 DIV 8'h14, 110 REM→MOD 8'h15.
    - All other combinations, including SLTU (f3 011), are illegal.
  - OP-IMM 0010011, a=rs1_val, b=sign-extended instr[31:20]:
    - f3 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND.
    - 001 SLL only when f7=0000000; 101 SRL when f7=0000000, SRA when f7=0100000. For shifts, b = zero-extended shamt instr[24:20].
    - SLTIU (011) and bad shift f7 are illegal.
  - LUI 0110111: ADD, a=0, b={instr[31:12],12'h0}.
  - AUIPC 0010111: ADD, a=i_pc, b={instr[31:12],12'h0}.
  - Any other opcode is illegal.
- Illegal encoding: slot still loads with o_valid=1, o_illegal=1, o_alu_op=NOP, o_a=o_b=0, o_we=0. o_rd = instr[11:7] always.
- No combinational path from i_instr to any output except via the register. o_ready depends only on o_valid and i_ready.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU op code constants (NOP/ADD/SUB/AND/OR/XOR/SLT/SLL/SRL/SRA/INV/MUL/DIV/MOD), moved out of the ALU source so ALU and issue stage share one definition;
  - RV32 opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - a decoded-bundle struct {op, a, b, rd, we, illegal}.
- One combinational sub-module, alu_op_decode (instr, pc, rs1, rs2 → bundle). The top holds only the register slot and handshake.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), rs1=0x10, i_ready=1 → next cycle o_valid=1, op=8'h11, a=0x10, b=0xFFFFFFFB, rd=1, we=1.
- SUB x3,x4,x5 (0x405201B3), rs1=7, rs2=9 → op=8'h12, a=7, b=9, rd=3. SRAI x1,x1,3 (0x4030D093) → op=8'h35, b=3.
- LUI x5,0x12345 (0x123452B7) → op=8'h11, a=0, b=0x12345000. AUIPC with same immediate field, pc=0x100 → a=0x100.
- SLTU x3,x1,x2 (0x0020B1B3) → o_valid=1, o_illegal=1, op=8'h00, we=0. Opcode 0x7F → illegal.
- Backpressure: load ADDI, hold i_ready=0 for 3 cycles → outputs stable and o_ready=0. Raise i_ready with i_valid=1 → old instruction consumed and new one loaded on the same edge.
- Flush while o_valid=1 and i_valid=1 → next cycle o_valid=0 and the input is not captured. Drop i_rst_n mid-hold → o_valid=0 and op=NOP immediately, without waiting for a clock edge.
